// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA frame RAM write path.
package vga_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int ADDR_W       = 19;
    localparam int DATA_W       = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VBL = 2'd1,
        WRITE    = 2'd2,
        DONE     = 2'd3
    } fbw_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Raster position counters for the frame RAM write side; index always equals y*H_RES+x.
module fb_addr_gen #(
    parameter int H_RES  = vga_pkg::H_RES,
    parameter int V_RES  = vga_pkg::V_RES,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    input  logic              restart_at_1,
    output logic [ADDR_W-1:0] index,
    output logic              last
);

    localparam int FRAME_PIXELS = H_RES * V_RES;
    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = $clog2(V_RES + 1);

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;

    // A restart means the accepted pixel landed at address 0, so the next one is (x=1, y=0).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x     <= '0;
            y     <= '0;
            index <= '0;
        end else if (restart_at_1) begin
            x     <= X_W'(1);
            y     <= '0;
            index <= ADDR_W'(1);
        end else if (inc) begin
            if (x == X_W'(H_RES - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
            index <= index + 1'b1;
        end
    end

    assign last = (index == ADDR_W'(FRAME_PIXELS - 1));

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes a valid/ready pixel stream raster-order into the frame RAM, optionally
// holding frame start until the falling edge of vertical sync.
module frame_buffer_writer #(
    parameter int H_RES    = vga_pkg::H_RES,
    parameter int V_RES    = vga_pkg::V_RES,
    parameter int ADDR_W   = vga_pkg::ADDR_W,
    parameter int DATA_W   = vga_pkg::DATA_W,
    parameter bit SYNC_VBL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                vga_vs,
    input  logic [DATA_W-1:0]   pix_in,
    input  logic                pix_sof,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_we,
    output logic                busy,
    output logic                frame_done,
    output logic                sof_err,
    output vga_pkg::fbw_state_t state_dbg
);

    import vga_pkg::*;

    fbw_state_t        state;
    fbw_state_t        state_d;
    logic              vs_prev;
    logic              vs_fall;
    logic              accept;
    logic              sof_restart;
    logic              last;
    logic [ADDR_W-1:0] index;

    // Handshake: a pixel transfers on any cycle where pix_valid and pix_ready are both 1;
    // pix_ready depends only on state, never on pix_valid, and the producer holds data until then.
    assign accept      = pix_valid & pix_ready;
    assign sof_restart = accept & pix_sof & (index != '0);
    assign vs_fall     = vs_prev & ~vga_vs;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (start) state_d = SYNC_VBL ? WAIT_VBL : WRITE;
            WAIT_VBL: if (vs_fall) state_d = WRITE;
            WRITE:    if (accept && last && !sof_restart) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            vs_prev <= 1'b1;
        end else begin
            state   <= state_d;
            vs_prev <= vga_vs;
        end
    end

    // Registered outputs; ready and busy track the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            pix_ready  <= (state_d == WRITE);
            busy       <= (state_d != IDLE);
            frame_done <= (state == DONE);
            mem_we     <= accept;
            sof_err    <= sof_restart;
            if (accept) begin
                mem_addr <= sof_restart ? '0 : index;
                mem_data <= pix_in;
            end
        end
    end

    fb_addr_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (state == DONE),
        .inc         (accept),
        .restart_at_1(sof_restart),
        .index       (index),
        .last        (last)
    );

    assign state_dbg = state;

endmodule
